// File: rtl/seq_wide_adder_ctrl.sv
// Wide add/subtract sequencer: one shared 8-bit adder slice processes the operands
// LSB byte first, one byte per clock, with valid/ready handshakes on both sides.

module adder8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};
endmodule

module seq_wide_adder_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NWORDS-1:0]   a,
  input  logic [8*NWORDS-1:0]   b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NWORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);
  localparam int W    = 8 * NWORDS;
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [W-1:0]      r_opA;
  logic [W-1:0]      r_opB;
  logic              r_sub;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [IDXW+2:0]   w_base;
  logic [7:0]        w_sliceA;
  logic [7:0]        w_sliceB;
  logic [7:0]        w_addSum;
  logic              w_addCout;
  logic              w_lastSlice;

  // Byte offset of the current slice; subtraction feeds the inverted B byte.
  assign w_base      = {r_idx, 3'b000};
  assign w_sliceA    = r_opA[w_base +: 8];
  assign w_sliceB    = r_opB[w_base +: 8] ^ {8{r_sub}};
  assign w_lastSlice = (r_idx == LAST_IDX);

  adder8b u_adder (
    .a  (w_sliceA),
    .b  (w_sliceB),
    .ci (r_carry),
    .s  (w_addSum),
    .co (w_addCout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_nextState = RUN;
      RUN:     if (w_lastSlice) w_nextState = DONE;
      DONE:    if (out_ready)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_sub   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA   <= a;
            r_opB   <= b;
            r_sub   <= sub;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[w_base +: 8] <= w_addSum;
          r_carry            <= w_addCout;
          // Index returns to zero after the top slice so it never points past the operand.
          if (w_lastSlice) begin
            r_idx  <= '0;
            r_cout <= w_addCout;
            r_ovf  <= (w_sliceA[7] == w_sliceB[7]) && (w_addSum[7] != w_sliceA[7]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Scoreboard bench for seq_wide_adder_ctrl: expected results come from plain
// 64-bit arithmetic on whole operands and are checked by an independent monitor.

module tb_seq_wide_adder_ctrl;
  localparam int NWORDS = 4;
  localparam int W      = 8 * NWORDS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  seq_wide_adder_ctrl #(.NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic; overflow means the signed result leaves the 32-bit range.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub, input logic mcin);
    exp_t           e;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned tot;
    int             ia;
    int             ib;
    longint         sa;
    longint         sb;
    longint         sres;
    ua = {32'd0, ma};
    ub = {32'd0, mb};
    ia = ma;
    ib = mb;
    sa = ia;
    sb = ib;
    if (msub) begin
      tot    = ua - ub;
      e.cout = (ua >= ub);
      sres   = sa - sb;
    end else begin
      tot    = ua + ub + {63'd0, mcin};
      e.cout = tot[32];
      sres   = sa + sb + {63'd0, mcin};
    end
    e.sum = tot[31:0];
    e.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tsub, input logic tcin);
    int n;
    @(negedge clk);
    a        = ta;
    b        = tb;
    sub      = tsub;
    cin      = tcin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_in_ready", 64'(in_ready), 64'd1);
    sbQ.push_back(model(ta, tb, tsub, tcin));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_idle", 64'(in_ready), 64'd1);
  endtask

  task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tsub, input logic tcin);
    applyStimulus(ta, tb, tsub, tcin);
    waitIdle();
  endtask

  // Monitor: every completed output handshake is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_output: got sum 0x%0h with no pending request", sum);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sb_sum",  64'(sum),  64'(e.sum));
          checkOutput("sb_cout", 64'(cout), 64'(e.cout));
          checkOutput("sb_ovf",  64'(ovf),  64'(e.ovf));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy",      64'(busy),      64'd0);
    checkOutput("reset_sum",       64'(sum),       64'd0);
    checkOutput("reset_cout",      64'(cout),      64'd0);
    checkOutput("reset_ovf",       64'(ovf),       64'd0);
    rst = 1'b0;

    $display("[TB] basic add with latency");
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    for (int k = 0; k < NWORDS; k++) begin
      @(negedge clk);
      checkOutput("latency_out_valid", 64'(out_valid), 64'd0);
      checkOutput("run_in_ready",      64'(in_ready),  64'd0);
      checkOutput("run_busy",          64'(busy),      64'd1);
    end
    @(negedge clk);
    checkOutput("latency_done", 64'(out_valid), 64'd1);
    waitIdle();

    $display("[TB] carry ripple and signed overflow");
    runOp(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    runOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

    $display("[TB] subtract");
    runOp(32'd5, 32'd7, 1'b1, 1'b1);
    runOp(32'h8000_0000, 32'd1, 1'b1, 1'b0);

    $display("[TB] output backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_sum",       64'(sum),       64'(sbQ[0].sum));
      checkOutput("bp_cout",      64'(cout),      64'(sbQ[0].cout));
      checkOutput("bp_ovf",       64'(ovf),       64'(sbQ[0].ovf));
      checkOutput("bp_in_ready",  64'(in_ready),  64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_release_in_ready",  64'(in_ready),  64'd1);
    checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_release_busy",      64'(busy),      64'd0);

    $display("[TB] operand stability");
    applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    for (int k = 0; k < NWORDS; k++) begin
      @(negedge clk);
      a   = $urandom;
      b   = $urandom;
      sub = ~sub;
      cin = ~cin;
    end
    waitIdle();

    $display("[TB] reset mid-operation");
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    void'(sbQ.pop_back());
    checkOutput("abort_in_ready",  64'(in_ready),  64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_sum",       64'(sum),       64'd0);
    checkOutput("abort_cout",      64'(cout),      64'd0);
    rst = 1'b0;
    runOp(32'd1, 32'd1, 1'b0, 1'b0);

    $display("[TB] randomized operations");
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = (k % 8 == 3) ? ra : 32'($urandom);
      runOp(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/seq_wide_adder_ctrl.md
Name: seq_wide_adder_ctrl

Overview:
Multi-cycle sequencer that performs wide add/subtract by time-sharing one adder8b instance, one 8-bit slice per clock, LSB slice first. It holds a carry register between slices and uses a valid/ready handshake on both input and output. Operand width is 8*NWORDS. It serves datapaths that need wide arithmetic without replicating ripple adders.

Parameters:
NWORDS, 4, number of 8-bit slices; operand/result width = 8*NWORDS; legal range 2..32

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
a  input  8*NWORDS  operand A
b  input  8*NWORDS  operand B
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
cin  input  1  carry in, used only when sub=0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  8*NWORDS  result
cout  output  1  final carry out; in sub mode, 1 = no borrow (a >= b unsigned)
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (rst=1 at edge): state IDLE, slice index 0, carry reg 0, captured operands 0, sum 0, cout 0, ovf 0, out_valid 0, busy 0. Reset overrides any other event in the same cycle.
- Reset during RUN or DONE aborts the operation. No out_valid is produced, and no partial result is visible after reset.
- States are IDLE, RUN and DONE. in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE: when in_valid and in_ready are both high at an edge, capture a, b and sub. Set carry reg <= sub ? 1 : cin. Set idx <= 0 and go to RUN.
- a, b, sub and cin are sampled only at acceptance. Changes to them afterwards do not affect the result.
- RUN, each cycle:
  - Drive adder8b with a[8*idx +: 8], b[8*idx +: 8] ^ {8{sub}}, and carry reg.
  - Write the adder sum into sum[8*idx +: 8]. Set carry reg <= adder cout. Increment idx.
- RUN, final slice (idx==NWORDS-1):
  - cout <= adder cout.
  - ovf <= (a_msb == b'_msb) && (s_msb != a_msb), where b' is the inverted-if-sub operand and s_msb is the adder sum MSB.
  - Go to DONE.
- Latency: a request accepted at edge T gives out_valid=1 in the cycle following edge T+NWORDS, i.e. exactly NWORDS cycles of RUN.
- The sum register holds partial values during RUN. Its value is meaningful only while out_valid=1.
- DONE: sum, cout and ovf stay stable until the edge where out_valid and out_ready are both high. At that edge, go to IDLE.
  - sum, cout and ovf keep their values in IDLE until the next operation overwrites them.
- No overlap: in_ready=0 in RUN and DONE, and in_valid is ignored there.
  - Peak throughput is one operation per NWORDS+2 cycles: accept, NWORDS RUN cycles, DONE handshake.
- Wrap-around: the result is modulo 2^(8*NWORDS). The carry out of the top slice appears only on cout.
- Exactly one adder8b instance. No other adder exists in the datapath. idx width is clog2(NWORDS), minimum 1.

Test Plan:
All scenarios use NWORDS=4.
1. Basic add with latency. a=0x000000FF, b=0x00000001, sub=0, cin=0 -> sum=0x00000100, cout=0, ovf=0. out_valid rises 4 cycles after the accept edge; in_ready=0 throughout.
2. Full carry ripple. a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0. Second op: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
3. Subtract. a=5, b=7, sub=1, cin=1 (must be ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Second op: a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
4. Output backpressure. Hold out_ready=0 for 10 cycles after out_valid, and toggle a, b and in_valid during that time -> sum, cout and ovf unchanged, in_ready=0, no new request accepted. Then raise out_ready=1 -> state IDLE and in_ready=1 in the next cycle.
5. Operand stability. Change a and b every cycle during RUN -> the result equals the values captured at acceptance.
6. Reset mid-operation. Assert rst in the 3rd RUN cycle of 0xFFFFFFFF+1 -> next cycle: in_ready=1, out_valid=0, sum=0, cout=0. A following op 1+1 with cin=0 gives sum=2, cout=0, showing the carry reg was cleared.
